key_code_lock: RTL
==================

// Module: key_code_lock
// PURPOSE
//  Keypad code lock; sits directly downstream of key_scan and consumes its one-cycle flag/data key events.
//  Collects CODE_LEN digits, checks them against a stored code on ENTER and drives unlock, error and alarm outputs.
//  Enforces an inactivity timeout, a failed-attempt lockout, and a code change while open.
//  Exposes the entry buffer for a downstream seven-segment driver.
// PARAMETERS
//  CLK_FREQ      50_000_000  clk frequency in Hz; ms tick every CLK_FREQ/1000 cycles
//  CODE_LEN      4           digits per code (1..8)
//  DEFAULT_CODE  32'h1234    reset code, BCD, low CODE_LEN nibbles used
//  TIMEOUT_MS    5000        inactivity timeout in ENTRY/SET
//  OPEN_MS       3000        unlock hold time
//  MAX_FAIL      3           consecutive failures that trigger lockout
//  LOCKOUT_MS    10000       alarm/lockout duration
// PORTS
//  clk        in   1            system clock
//  rst        in   1            asynchronous reset, active-high
//  key_flag   in   1            one-cycle key-press strobe from key_scan
//  key_data   in   4            key code, valid when key_flag=1
//  unlock     out  1            high while state=OPEN
//  alarm      out  1            high while state=LOCKOUT
//  err        out  1            one-cycle pulse on rejected code or short SET commit
//  digit_cnt  out  4            digits currently in buffer (0..CODE_LEN)
//  disp_data  out  4*CODE_LEN   entry buffer, BCD; newest digit in bits [3:0]
// BEHAVIOUR
//  - Reset: state IDLE; unlock/alarm/err=0; digit_cnt=0; disp_data=0; fail_cnt=0; code=DEFAULT_CODE; timer=0.
//  - Key map: 0-9 digit; 10 SET; 14 CLEAR; 15 ENTER; 11,12,13 ignored. All keys are acted on only in the cycle of key_flag.
//  - ms_timer counts ms ticks. It is cleared on every accepted key and on every state change.
//    Timer compares use >= the limit. Width is 16 bits.
//  - IDLE: digit -> buffer={0..,d}, cnt=1, go ENTRY. All other keys are ignored.
//  - ENTRY:
//     digit with cnt<CODE_LEN -> shift left 4, insert d, cnt++.
//     digit with cnt=CODE_LEN -> ignored; the timer is still cleared.
//     CLEAR -> buffer=0, cnt=0, go IDLE.
//     ENTER -> go CHECK.
//     timer>=TIMEOUT_MS -> buffer=0, cnt=0, go IDLE.
//  - CHECK (exactly 1 cycle; keys ignored):
//     match (cnt==CODE_LEN && buffer==code) -> fail_cnt=0, go OPEN.
//     else if fail_cnt+1==MAX_FAIL -> err=1, fail_cnt=0, go LOCKOUT.
//     else -> err=1, fail_cnt++, go IDLE.
//     The buffer is cleared on exit in every case.
//  - OPEN: unlock=1. SET key -> go SET. timer>=OPEN_MS -> go IDLE. Other keys are ignored.
//  - SET: digits fill the buffer as in ENTRY.
//     ENTER with cnt==CODE_LEN -> code=buffer, go IDLE.
//     ENTER with cnt<CODE_LEN -> err=1, buffer cleared, stay in SET.
//     CLEAR or timeout -> go IDLE with the code unchanged.
//  - LOCKOUT: alarm=1, all keys ignored. timer>=LOCKOUT_MS -> go IDLE.
//  - Latency: ENTER flag in cycle N -> CHECK in N+1 -> unlock or err registered high in N+2.
//  - Outputs are registered. err is high for exactly one cycle.
//  - Async rst mid-operation restores all reset values, including code=DEFAULT_CODE.
// STRUCTURE
//  - key_lock_defs.vh: state encodings (IDLE, ENTRY, CHECK, OPEN, SET, LOCKOUT) and key-code localparams (KEY_SET=10, KEY_CLR=14, KEY_ENT=15).
//  - Sub-module ms_tick_gen(clk, rst, tick): divider emitting a one-cycle 1 ms tick.
//  - Top: one FSM, entry shift buffer with count, code register, fail counter, ms_timer.
// TESTING (CLK_FREQ=50_000 so 1 ms=50 cycles; TIMEOUT_MS=20, OPEN_MS=10, LOCKOUT_MS=30; key_scan model drives flag/data)
//  1. Reset -> unlock=alarm=err=0, digit_cnt=0, disp_data=16'h0000.
//  2. Keys 1,2,3,4,ENTER -> disp_data=16'h1234 before ENTER; unlock=1 two cycles after the ENTER flag, held 10 ms, then 0.
//  3. Keys 1,2,3,5,ENTER three times -> err pulses on the first two; on the third, alarm=1 for 30 ms with keys ignored; then 1234,ENTER opens.
//  4. Keys 1,2 then idle 20 ms -> digit_cnt=0, disp_data=0, state IDLE.
//  5. Open with 1234; SET; 9,8,7,6,ENTER -> 1234,ENTER gives err; 9876,ENTER gives unlock.
//  6. Keys 1,2,3,4,5,ENTER -> 5 ignored and lock opens. Keys 1,2,CLEAR -> cnt=0. SET with 2 digits then ENTER -> err, code unchanged.

Source files
------------

// File: rtl/key_code_lock_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : key_code_lock_pkg
//  Description : Shared state encodings, key codes and a digit-decode helper
//                for the keypad code lock.
//  Revision    : 1.0 - initial release
// ============================================================================
package key_code_lock_pkg;

    typedef logic [2:0] state_t;

    localparam state_t c_st_idle    = 3'd0;
    localparam state_t c_st_entry   = 3'd1;
    localparam state_t c_st_check   = 3'd2;
    localparam state_t c_st_open    = 3'd3;
    localparam state_t c_st_set     = 3'd4;
    localparam state_t c_st_lockout = 3'd5;

    localparam logic [3:0] c_key_set = 4'd10;
    localparam logic [3:0] c_key_clr = 4'd14;
    localparam logic [3:0] c_key_ent = 4'd15;

    // Keys 0..9 are digits; 10..15 are commands or unused.
    function automatic logic is_digit(input logic [3:0] key);
        return (key <= 4'd9);
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_code_lock_ms_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : ms_tick_gen
//  Description : Clock divider producing a registered one-cycle pulse every
//                CLK_FREQ/1000 clock cycles (1 ms time base).
//  Ports       : clk  - system clock
//                rst  - asynchronous reset, active-high
//                tick - one-cycle 1 ms strobe
//  Revision    : 1.0 - initial release
// ============================================================================
module ms_tick_gen #(
    parameter int CLK_FREQ = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int c_div = (CLK_FREQ / 1000 > 0) ? (CLK_FREQ / 1000) : 1;
    localparam int c_cw  = (c_div > 1) ? $clog2(c_div) : 1;

    logic [c_cw-1:0] r_cnt;
    logic            r_tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (r_cnt == c_cw'(c_div - 1)) begin
            r_cnt  <= '0;
            r_tick <= 1'b1;
        end else begin
            r_cnt  <= r_cnt + 1'b1;
            r_tick <= 1'b0;
        end
    end

    assign tick = r_tick;

endmodule
`default_nettype wire

// File: rtl/key_code_lock.sv
`default_nettype none
// ============================================================================
//  Module      : key_code_lock
//  Description : Keypad code lock. Collects CODE_LEN BCD digits from one-cycle
//                key events, compares them with a stored code on ENTER, and
//                drives unlock / err / alarm. Inactivity timeout, failed-attempt
//                lockout and code change while open are supported.
//  Ports       : clk, rst            - clock, asynchronous active-high reset
//                key_flag, key_data  - one-cycle key strobe and key code
//                unlock              - high while the lock is open
//                alarm               - high during lockout
//                err                 - one-cycle pulse on rejected entry
//                digit_cnt           - digits held in the entry buffer
//                disp_data           - entry buffer, newest digit in [3:0]
//  Revision    : 1.0 - initial release
// ============================================================================
module key_code_lock
    import key_code_lock_pkg::*;
#(
    parameter int          CLK_FREQ     = 50_000_000,
    parameter int          CODE_LEN     = 4,
    parameter logic [31:0] DEFAULT_CODE = 32'h1234,
    parameter int          TIMEOUT_MS   = 5000,
    parameter int          OPEN_MS      = 3000,
    parameter int          MAX_FAIL     = 3,
    parameter int          LOCKOUT_MS   = 10000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  key_flag,
    input  logic [3:0]            key_data,
    output logic                  unlock,
    output logic                  alarm,
    output logic                  err,
    output logic [3:0]            digit_cnt,
    output logic [4*CODE_LEN-1:0] disp_data
);

    localparam int c_w = 4 * CODE_LEN;

    state_t         r_state, w_state_nxt;
    logic [c_w-1:0] r_buf, w_buf_nxt;
    logic [3:0]     r_cnt, w_cnt_nxt;
    logic [c_w-1:0] r_code, w_code_nxt;
    logic [7:0]     r_fail, w_fail_nxt;
    logic [15:0]    r_timer;
    logic           r_unlock, r_alarm, r_err;
    logic           w_err_nxt;
    logic           w_key_acc;
    logic           w_tick;
    logic           w_digit;
    logic           w_full;
    logic           w_timer_clr;
    logic [c_w+3:0] w_ext;
    logic [c_w-1:0] w_buf_ins;

    ms_tick_gen #(
        .CLK_FREQ (CLK_FREQ)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (w_tick)
    );

    // Shift-in through a widened vector so CODE_LEN=1 needs no special case.
    assign w_ext     = {r_buf, key_data};
    assign w_buf_ins = w_ext[c_w-1:0];
    assign w_digit   = is_digit(key_data);
    assign w_full    = (r_cnt == 4'(CODE_LEN));

    always_comb begin
        w_state_nxt = r_state;
        w_buf_nxt   = r_buf;
        w_cnt_nxt   = r_cnt;
        w_code_nxt  = r_code;
        w_fail_nxt  = r_fail;
        w_err_nxt   = 1'b0;
        w_key_acc   = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (key_flag && w_digit) begin
                    w_key_acc   = 1'b1;
                    w_buf_nxt   = c_w'(key_data);
                    w_cnt_nxt   = 4'd1;
                    w_state_nxt = c_st_entry;
                end
            end
            c_st_entry, c_st_set: begin
                if (key_flag && w_digit) begin
                    // A digit on a full buffer is dropped but still counts as
                    // activity for the inactivity timer.
                    w_key_acc = 1'b1;
                    if (!w_full) begin
                        w_buf_nxt = w_buf_ins;
                        w_cnt_nxt = r_cnt + 4'd1;
                    end
                end else if (key_flag && key_data == c_key_clr) begin
                    w_key_acc   = 1'b1;
                    w_buf_nxt   = '0;
                    w_cnt_nxt   = 4'd0;
                    w_state_nxt = c_st_idle;
                end else if (key_flag && key_data == c_key_ent) begin
                    w_key_acc = 1'b1;
                    if (r_state == c_st_entry) begin
                        w_state_nxt = c_st_check;
                    end else if (w_full) begin
                        w_code_nxt  = r_buf;
                        w_buf_nxt   = '0;
                        w_cnt_nxt   = 4'd0;
                        w_state_nxt = c_st_idle;
                    end else begin
                        // Short commit: reject and let the user retype.
                        w_err_nxt = 1'b1;
                        w_buf_nxt = '0;
                        w_cnt_nxt = 4'd0;
                    end
                end else if (r_timer >= 16'(TIMEOUT_MS)) begin
                    w_buf_nxt   = '0;
                    w_cnt_nxt   = 4'd0;
                    w_state_nxt = c_st_idle;
                end
            end
            c_st_check: begin
                w_buf_nxt = '0;
                w_cnt_nxt = 4'd0;
                if (w_full && r_buf == r_code) begin
                    w_fail_nxt  = 8'd0;
                    w_state_nxt = c_st_open;
                end else if (r_fail == 8'(MAX_FAIL - 1)) begin
                    w_err_nxt   = 1'b1;
                    w_fail_nxt  = 8'd0;
                    w_state_nxt = c_st_lockout;
                end else begin
                    w_err_nxt   = 1'b1;
                    w_fail_nxt  = r_fail + 8'd1;
                    w_state_nxt = c_st_idle;
                end
            end
            c_st_open: begin
                if (key_flag && key_data == c_key_set) begin
                    w_key_acc   = 1'b1;
                    w_state_nxt = c_st_set;
                end else if (r_timer >= 16'(OPEN_MS)) begin
                    w_state_nxt = c_st_idle;
                end
            end
            c_st_lockout: begin
                if (r_timer >= 16'(LOCKOUT_MS)) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: begin
                w_buf_nxt   = '0;
                w_cnt_nxt   = 4'd0;
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    assign w_timer_clr = w_key_acc || (w_state_nxt != r_state);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_st_idle;
            r_buf    <= '0;
            r_cnt    <= 4'd0;
            r_code   <= DEFAULT_CODE[c_w-1:0];
            r_fail   <= 8'd0;
            r_timer  <= 16'd0;
            r_unlock <= 1'b0;
            r_alarm  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_buf    <= w_buf_nxt;
            r_cnt    <= w_cnt_nxt;
            r_code   <= w_code_nxt;
            r_fail   <= w_fail_nxt;
            r_unlock <= (w_state_nxt == c_st_open);
            r_alarm  <= (w_state_nxt == c_st_lockout);
            r_err    <= w_err_nxt;
            if (w_timer_clr) begin
                r_timer <= 16'd0;
            end else if (w_tick && r_timer != 16'hFFFF) begin
                r_timer <= r_timer + 16'd1;
            end
        end
    end

    assign unlock    = r_unlock;
    assign alarm     = r_alarm;
    assign err       = r_err;
    assign digit_cnt = r_cnt;
    assign disp_data = r_buf;

endmodule
`default_nettype wire
